dmem_access_ctrl: RTL and testbench

Multi-cycle data-memory access controller for the MEM stage, between the EX/MEM pipeline register and the MEM/WB pipeline register. It converts single-cycle load/store controls into a req/ack handshake with a variable-latency data memory. It freezes the pipeline with `stall_o` while an access is outstanding and presents load data on `rdata_o` for the MEM/WB register to capture. A cycle-count timeout ensures the pipeline always recovers.

---
 rtl/dmem_access_ctrl.sv | 146 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access controller.
// Turns single-cycle load/store controls from EX/MEM into a req/ack
// transaction with a variable-latency memory, stalling the pipeline
// while the access is outstanding. A wait counter bounds every access.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (rejects misaligned
// addresses without issuing a memory request).
//
// Memory handshake: mem_req_o is a registered level held high from the
// first WAIT cycle until the cycle mem_ack_i is seen; address, data and
// write enable are stable for that whole window. mem_ack_i (with
// mem_rdata_i) is only looked at while mem_req_o is high, and a single
// acked cycle completes the access.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             active;
    logic             misaligned;
    logic             timeout_hit;

    assign active      = mem_read_i | mem_write_i;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT));
    assign state_o     = state;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // Next-state and combinational stall; DONE releases the pipeline.
    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        case (state)
            IDLE: begin
                if (active) begin
                    stall_o    = 1'b1;
                    state_next = misaligned ? DONE : WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem_ack_i || timeout_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register plus registered memory-side and result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            state <= state_next;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (active) begin
                        if (misaligned) begin
                            // Rejected access: no request, error in DONE.
                            err_o <= 1'b1;
                            if (!mem_write_i) begin
                                rdata_o <= '0;
                            end
                        end else begin
                            // Write wins when both controls are high.
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= mem_write_i;
                            mem_addr_o  <= addr_i;
                            mem_wdata_o <= wdata_i;
                            wait_cnt    <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        // Ack beats a coinciding timeout.
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        if (!mem_we_o) begin
                            rdata_o <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                        if (!mem_we_o) begin
                            rdata_o <= '0;
                        end
                    end else if (wait_cnt < CNT_W'(TIMEOUT)) begin
                        // Saturating: never wraps back to zero.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed testbench for dmem_access_ctrl (TIMEOUT = 4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_access_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observations collected by the driver task.
    int            obs_stall;
    int            obs_req_cycles;
    logic          obs_done;
    logic          obs_err_early;
    logic          obs_err;
    logic [DW-1:0] obs_rdata;
    logic          obs_req_done;
    logic          obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata;
    logic [1:0]    obs_first_state;

    dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_read_i  (mem_read),
        .mem_write_i (mem_write),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .stall_o     (stall),
        .rdata_o     (rdata),
        .err_o       (err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata),
        .state_o     (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver: issues one access from IDLE, acks ack_delay WAIT cycles after
    // mem_req rises (negative = never), and records what it saw until DONE.
    task automatic do_access(input logic r, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input int ack_delay,
                             input logic [DW-1:0] rd);
        int wait_cyc;
        @(negedge clk);
        mem_read  = r;
        mem_write = w;
        addr      = a;
        wdata     = d;
        mem_ack   = 1'b0;
        obs_stall = 0;
        obs_req_cycles = 0;
        obs_done  = 1'b0;
        obs_err_early = 1'b0;
        obs_err   = 1'b0;
        obs_rdata = '0;
        obs_req_done = 1'b1;
        obs_we    = 1'b0;
        obs_addr  = '0;
        obs_wdata = '0;
        wait_cyc  = 0;
        #1;
        obs_first_state = state;
        for (int c = 0; c < 64 && !obs_done; c++) begin
            if (c != 0) #1;
            if (stall) begin
                obs_stall++;
                obs_err_early = obs_err_early | err;
                if (mem_req) begin
                    obs_req_cycles++;
                    obs_we    = mem_we;
                    obs_addr  = mem_addr;
                    obs_wdata = mem_wdata;
                    if (ack_delay >= 0 && wait_cyc == ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rd;
                    end
                    wait_cyc++;
                end
            end else if (obs_stall > 0) begin
                obs_done     = 1'b1;
                obs_err      = err;
                obs_rdata    = rdata;
                obs_req_done = mem_req;
                mem_read     = 1'b0;
                mem_write    = 1'b0;
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if ({stall, err, mem_req, mem_we} !== 4'b0000) $display("FAIL reset_ctrl got=%b exp=0000", {stall, err, mem_req, mem_we}); else pass_cnt++;
        total_cnt++; if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata); else pass_cnt++;
        total_cnt++; if ({mem_addr, mem_wdata} !== '0) $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); else pass_cnt++;
        total_cnt++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else pass_cnt++;
    endtask

    task automatic test_load_ack3;
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEADBEEF);
        total_cnt++; if (obs_done !== 1'b1) $display("FAIL load_done got=%b exp=1", obs_done); else pass_cnt++;
        total_cnt++; if (obs_stall != 5) $display("FAIL load_stall got=%0d exp=5", obs_stall); else pass_cnt++;
        total_cnt++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata got=%h exp=deadbeef", obs_rdata); else pass_cnt++;
        total_cnt++; if ({obs_err, obs_err_early} !== 2'b00) $display("FAIL load_err got=%b exp=00", {obs_err, obs_err_early}); else pass_cnt++;
        total_cnt++; if ({obs_req_done, obs_we} !== 2'b00) $display("FAIL load_req_we got=%b exp=00", {obs_req_done, obs_we}); else pass_cnt++;
        total_cnt++; if (obs_addr !== 32'h40) $display("FAIL load_addr got=%h exp=40", obs_addr); else pass_cnt++;
    endtask

    task automatic test_store_ack0;
        do_access(1'b0, 1'b1, 32'h10, 32'h12345678, 0, 32'hFFFF0000);
        total_cnt++; if (obs_stall != 2) $display("FAIL store_stall got=%0d exp=2", obs_stall); else pass_cnt++;
        total_cnt++; if (obs_we !== 1'b1) $display("FAIL store_we got=%b exp=1", obs_we); else pass_cnt++;
        total_cnt++; if (obs_wdata !== 32'h12345678) $display("FAIL store_wdata got=%h exp=12345678", obs_wdata); else pass_cnt++;
        total_cnt++; if (obs_addr !== 32'h10) $display("FAIL store_addr got=%h exp=10", obs_addr); else pass_cnt++;
        total_cnt++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL store_rdata_kept got=%h exp=deadbeef", obs_rdata); else pass_cnt++;
        total_cnt++; if (obs_err !== 1'b0) $display("FAIL store_err got=%b exp=0", obs_err); else pass_cnt++;
    endtask

    task automatic test_timeout;
        do_access(1'b1, 1'b0, 32'h44, 32'h0, -1, 32'h0);
        total_cnt++; if (obs_stall != TO + 2) $display("FAIL timeout_stall got=%0d exp=%0d", obs_stall, TO + 2); else pass_cnt++;
        total_cnt++; if (obs_rdata !== '0) $display("FAIL timeout_rdata got=%h exp=0", obs_rdata); else pass_cnt++;
        total_cnt++; if ({obs_err, obs_err_early} !== 2'b10) $display("FAIL timeout_err got=%b exp=10", {obs_err, obs_err_early}); else pass_cnt++;
        total_cnt++; if (obs_req_done !== 1'b0) $display("FAIL timeout_req_drop got=%b exp=0", obs_req_done); else pass_cnt++;
        #1;
        total_cnt++; if (err !== 1'b0) $display("FAIL timeout_err_pulse got=%b exp=0", err); else pass_cnt++;
    endtask

    task automatic test_ack_at_timeout;
        do_access(1'b1, 1'b0, 32'h48, 32'h0, TO, 32'hA5A5_0001);
        total_cnt++; if (obs_stall != TO + 2) $display("FAIL ack_to_stall got=%0d exp=%0d", obs_stall, TO + 2); else pass_cnt++;
        total_cnt++; if (obs_err !== 1'b0) $display("FAIL ack_to_err got=%b exp=0", obs_err); else pass_cnt++;
        total_cnt++; if (obs_rdata !== 32'hA5A5_0001) $display("FAIL ack_to_rdata got=%h exp=a5a50001", obs_rdata); else pass_cnt++;
    endtask

    task automatic test_read_write_both;
        do_access(1'b1, 1'b1, 32'h20, 32'h0BADF00D, 1, 32'h11111111);
        total_cnt++; if (obs_we !== 1'b1) $display("FAIL both_we got=%b exp=1", obs_we); else pass_cnt++;
        total_cnt++; if (obs_rdata !== 32'hA5A5_0001) $display("FAIL both_rdata_kept got=%h exp=a5a50001", obs_rdata); else pass_cnt++;
        total_cnt++; if (obs_stall != 3) $display("FAIL both_stall got=%0d exp=3", obs_stall); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0000_0111);
        total_cnt++; if (obs_rdata !== 32'h0000_0111) $display("FAIL b2b_first got=%h exp=00000111", obs_rdata); else pass_cnt++;
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 2, 32'h0000_0222);
        total_cnt++; if (obs_first_state !== 2'd0) $display("FAIL b2b_idle_start got=%0d exp=0", obs_first_state); else pass_cnt++;
        total_cnt++; if (obs_stall != 4) $display("FAIL b2b_stall got=%0d exp=4", obs_stall); else pass_cnt++;
        total_cnt++; if (obs_rdata !== 32'h0000_0222) $display("FAIL b2b_second got=%h exp=00000222", obs_rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait;
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 32'h80;
        @(negedge clk);   // WAIT cycle 1
        @(negedge clk);   // WAIT cycle 2
        #1;
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL rstwait_req_before got=%b exp=1", mem_req); else pass_cnt++;
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++; if ({mem_req, stall, state} !== 4'b0000) $display("FAIL rstwait_after got=%b exp=0000", {mem_req, stall, state}); else pass_cnt++;
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        total_cnt++; if (rdata !== '0) $display("FAIL rstwait_rdata got=%h exp=0", rdata); else pass_cnt++;
        total_cnt++; if ({mem_req, err, state} !== 4'b0000) $display("FAIL rstwait_idle got=%b exp=0000", {mem_req, err, state}); else pass_cnt++;
    endtask

    task automatic test_misaligned;
`ifdef DMEM_ALIGN_CHECK_EN
        do_access(1'b1, 1'b0, 32'h42, 32'h0, 0, 32'h77777777);
        total_cnt++; if (obs_stall != 1) $display("FAIL align_stall got=%0d exp=1", obs_stall); else pass_cnt++;
        total_cnt++; if (obs_req_cycles != 0) $display("FAIL align_no_req got=%0d exp=0", obs_req_cycles); else pass_cnt++;
        total_cnt++; if (obs_err !== 1'b1) $display("FAIL align_err got=%b exp=1", obs_err); else pass_cnt++;
        total_cnt++; if (obs_rdata !== '0) $display("FAIL align_rdata got=%h exp=0", obs_rdata); else pass_cnt++;
`else
        do_access(1'b1, 1'b0, 32'h42, 32'h0, 0, 32'h77777777);
        total_cnt++; if (obs_addr !== 32'h42) $display("FAIL noalign_addr got=%h exp=42", obs_addr); else pass_cnt++;
        total_cnt++; if (obs_stall != 2) $display("FAIL noalign_stall got=%0d exp=2", obs_stall); else pass_cnt++;
        total_cnt++; if ({obs_err, obs_rdata} !== {1'b0, 32'h77777777}) $display("FAIL noalign_result got=%b/%h exp=0/77777777", obs_err, obs_rdata); else pass_cnt++;
`endif
    endtask

    initial begin
        test_reset;
        test_load_ack3;
        test_store_ack0;
        test_timeout;
        test_ack_at_timeout;
        test_read_write_both;
        test_back_to_back;
        test_reset_mid_wait;
        test_misaligned;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Watchdog: the run must end on its own.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
